pwm_dac: RTL and testbench

Downstream output stage of the waveform generators. Consumes 8-bit samples from the DDS / WaveGen sample path, scales amplitude by a power of two, and renders each sample as one period of a counter-compare PWM on a single output pin. Requests the next sample once per PWM period. A loadable prescaler sets the PWM rate.

---
 rtl/wave_pkg.sv | 12 +
 rtl/tick_prescaler.sv | 43 ++++
 rtl/pwm_dac.sv | 108 ++++++++++
 tb/tb_pwm_dac.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared constants and types for the DDS / WaveGen / FuncGen sample path
// and its PWM output stage.
package wave_pkg;

    localparam int SAMPLE_W = 8;
    localparam int PRESC_W  = 5;
    localparam int AMP_W    = 2;

    // Power-of-two attenuation code: effective sample = raw >> amp.
    typedef logic [AMP_W-1:0] amp_t;

endpackage : wave_pkg

// File: rtl/tick_prescaler.sv
// Loadable down-counting prescaler producing the PWM counter tick enable.
// A reload value of N gives one tick every N+1 clock cycles.
module tick_prescaler #(
    parameter int PRESC_W = wave_pkg::PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld,
    input  logic [PRESC_W-1:0] presc_load,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_val_r;
    logic [PRESC_W-1:0] tcnt_r;

    // Tick when the down-counter is exhausted; a load cycle never ticks.
    always_comb begin
        tick = 1'b0;
        if (ld) begin
            tick = 1'b0;
        end else begin
            tick = (tcnt_r == {PRESC_W{1'b0}});
        end
    end

    // Reload register and down-counter; a load restarts the count immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_val_r <= {PRESC_W{1'b0}};
            tcnt_r      <= {PRESC_W{1'b0}};
        end else if (ld) begin
            presc_val_r <= presc_load;
            tcnt_r      <= presc_load;
        end else if (tick) begin
            presc_val_r <= presc_val_r;
            tcnt_r      <= presc_val_r;
        end else begin
            presc_val_r <= presc_val_r;
            tcnt_r      <= tcnt_r - PRESC_W'(1'b1);
        end
    end

endmodule : tick_prescaler

// File: rtl/pwm_dac.sv
// PWM output stage: each incoming sample, attenuated by a power of two,
// is rendered as one full counter-compare PWM period on pwm_out.
module pwm_dac #(
    parameter int SAMPLE_W = wave_pkg::SAMPLE_W,
    parameter int PRESC_W  = wave_pkg::PRESC_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld,
    input  logic [PRESC_W-1:0]  presc_load,
    input  logic [1:0]          amp_sel,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_req,
    output logic                overrun,
    output logic                pwm_out
);

    import wave_pkg::*;

    logic                tick_s;
    logic                wrap_s;
    amp_t                amp_s;
    logic [SAMPLE_W-1:0] src_s;

    logic [SAMPLE_W-1:0] pcnt_r;
    logic [SAMPLE_W-1:0] duty_r;
    logic [SAMPLE_W-1:0] last_r;
    logic [SAMPLE_W-1:0] pend_r;
    logic                pend_full_r;

    tick_prescaler #(
        .PRESC_W    (PRESC_W)
    ) u_tick_prescaler (
        .clk        (clk),
        .rst        (rst),
        .ld         (ld),
        .presc_load (presc_load),
        .tick       (tick_s)
    );

    assign amp_s  = amp_sel;
    assign wrap_s = tick_s && (pcnt_r == {SAMPLE_W{1'b1}});

    // Raw sample for the next period: a same-cycle strobe beats the pending
    // sample, and with nothing new the previous raw sample is reused so a
    // changed attenuation still takes effect.
    always_comb begin
        src_s = last_r;
        if (sample_valid) begin
            src_s = sample_in;
        end else if (pend_full_r) begin
            src_s = pend_r;
        end else begin
            src_s = last_r;
        end
    end

    // PWM counter, advanced once per prescaler tick and wrapping at full scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_r <= {SAMPLE_W{1'b0}};
        end else if (tick_s) begin
            pcnt_r <= pcnt_r + SAMPLE_W'(1'b1);
        end else begin
            pcnt_r <= pcnt_r;
        end
    end

    // Holding register and period-boundary duty update.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r      <= {SAMPLE_W{1'b0}};
            pend_full_r <= 1'b0;
            last_r      <= {SAMPLE_W{1'b0}};
            duty_r      <= {SAMPLE_W{1'b0}};
        end else if (wrap_s) begin
            pend_r      <= pend_r;
            pend_full_r <= 1'b0;
            last_r      <= src_s;
            duty_r      <= src_s >> amp_s;
        end else if (sample_valid) begin
            pend_r      <= sample_in;
            pend_full_r <= 1'b1;
            last_r      <= last_r;
            duty_r      <= duty_r;
        end else begin
            pend_r      <= pend_r;
            pend_full_r <= pend_full_r;
            last_r      <= last_r;
            duty_r      <= duty_r;
        end
    end

    // Registered status pulses and compare output.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_req <= 1'b0;
            overrun    <= 1'b0;
            pwm_out    <= 1'b0;
        end else begin
            sample_req <= wrap_s;
            overrun    <= sample_valid && !wrap_s && pend_full_r;
            pwm_out    <= (pcnt_r < duty_r);
        end
    end

endmodule : pwm_dac

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac: a table of per-period duty/period vectors plus
// hand-written sequences for attenuation timing, overrun, wrap bypass and reset.
module tb_pwm_dac;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld;
    logic [4:0] presc_load;
    logic [1:0] amp_sel;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_req;
    logic       overrun;
    logic       pwm_out;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0] presc;
        logic [1:0] amp;
        logic [7:0] sample;
        int         exp_high;
        int         exp_period;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    pwm_dac dut (
        .clk          (clk),
        .rst          (rst),
        .ld           (ld),
        .presc_load   (presc_load),
        .amp_sel      (amp_sel),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_req   (sample_req),
        .overrun      (overrun),
        .pwm_out      (pwm_out)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Runs until the next sample_req (inclusive), counting cycles, high
    // pwm_out cycles and overrun pulses along the way.
    task automatic measure(input string name, output int cycles, output int highs, output int ovr);
        cycles = 0;
        highs  = 0;
        ovr    = 0;
        do begin
            step();
            cycles++;
            highs += int'(pwm_out);
            ovr   += int'(overrun);
        end while (!sample_req && cycles < 3000);
        if (!sample_req) begin
            check({name, "_req_timeout"}, cycles, -1);
        end
    endtask

    task automatic load_presc(input logic [4:0] value);
        ld = 1'b1;
        presc_load = value;
        step();
        ld = 1'b0;
    endtask

    task automatic send(input logic [7:0] value);
        sample_in = value;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    initial begin
        int c, h, o;

        vecs[0] = '{5'd0, 2'd0, 8'd128, 128, 256};
        vecs[1] = '{5'd0, 2'd2, 8'd200,  50, 256};
        vecs[2] = '{5'd0, 2'd1, 8'd200, 100, 256};
        vecs[3] = '{5'd3, 2'd0, 8'd128, 512, 1024};
        vecs[4] = '{5'd1, 2'd3, 8'd255,  62, 512};
        vecs[5] = '{5'd0, 2'd0, 8'd255, 255, 256};
        vecs[6] = '{5'd0, 2'd0, 8'd0,     0, 256};
        vecs[7] = '{5'd2, 2'd1, 8'd7,     9, 768};

        rst = 1'b1;
        ld = 1'b0;
        presc_load = 5'd0;
        amp_sel = 2'd0;
        sample_in = 8'd0;
        sample_valid = 1'b0;
        repeat (3) step();
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_sample_req", int'(sample_req), 0);
        check("rst_overrun", int'(overrun), 0);

        // First wrap after reset: 256 ticks, ticking from the first free cycle.
        rst = 1'b0;
        measure("first_wrap", c, h, o);
        check("first_wrap_cycles", c, 256);
        check("first_wrap_highs", h, 0);

        for (int i = 0; i < 8; i++) begin
            load_presc(vecs[i].presc);
            amp_sel = vecs[i].amp;
            send(vecs[i].sample);
            measure($sformatf("vec%0d_apply", i), c, h, o);
            measure($sformatf("vec%0d", i), c, h, o);
            check($sformatf("vec%0d_highs", i), h, vecs[i].exp_high);
            check($sformatf("vec%0d_period", i), c, vecs[i].exp_period);
            check($sformatf("vec%0d_overrun", i), o, 0);
        end

        // Attenuation change mid-period only affects the following period.
        load_presc(5'd0);
        amp_sel = 2'd2;
        send(8'd200);
        measure("amp_apply", c, h, o);
        amp_sel = 2'd1;
        measure("amp_cur", c, h, o);
        check("amp_cur_highs", h, 50);
        measure("amp_next", c, h, o);
        check("amp_next_highs", h, 100);

        // Two strobes in one period: single overrun on the second, newest wins.
        amp_sel = 2'd0;
        send(8'd10);
        check("ovr_first_strobe", int'(overrun), 0);
        repeat (5) step();
        send(8'd20);
        check("ovr_second_strobe", int'(overrun), 1);
        measure("ovr_rest", c, h, o);
        check("ovr_rest_pulses", o, 0);
        measure("ovr_next", c, h, o);
        check("ovr_next_highs", h, 20);

        // Strobe exactly on the wrap cycle bypasses a pending sample.
        send(8'd33);
        o = 0;
        for (int k = 0; k < 254; k++) begin
            step();
            o += int'(overrun);
        end
        send(8'd77);
        o += int'(overrun);
        check("wrapbyp_req", int'(sample_req), 1);
        check("wrapbyp_overrun", o, 0);
        measure("wrapbyp_p1", c, h, o);
        check("wrapbyp_p1_highs", h, 77);
        check("wrapbyp_p1_overrun", o, 0);
        measure("wrapbyp_p2", c, h, o);
        check("wrapbyp_p2_highs", h, 77);

        // Reset mid-period with a large duty.
        send(8'd200);
        measure("rstmid_apply", c, h, o);
        repeat (50) step();
        check("rstmid_before", int'(pwm_out), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_pwm_out", int'(pwm_out), 0);
        check("rstmid_sample_req", int'(sample_req), 0);
        check("rstmid_overrun", int'(overrun), 0);
        measure("rstmid_wrap", c, h, o);
        check("rstmid_wrap_cycles", c, 256);
        check("rstmid_wrap_highs", h, 0);
        measure("rstmid_after", c, h, o);
        check("rstmid_after_highs", h, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pwm_dac
